// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 scancode decode path.
//   - Set-2 prefix bytes (extended, break, pause)
//   - keyboard status byte list and predicate
//   - 7-byte Pause tail that follows the leading E1
//   - decode FSM state enum
//   - ps2_evt_t: one decoded key event {pause, ext, rel, code}
package ps2_pkg;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    localparam int NUM_STATUS = 7;
    localparam logic [NUM_STATUS-1:0][7:0] STATUS_BYTES =
        {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

    // Bytes expected after the leading E1 of a Pause press, in arrival order.
    localparam int PAUSE_LEN = 7;
    localparam logic [0:PAUSE_LEN-1][7:0] PAUSE_TAIL =
        {8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXTBRK,
        ST_PAUSE
    } dec_state_t;

    typedef struct packed {
        logic       pause;
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_evt_t;

    function automatic logic is_status(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_STATUS; i++)
            if (b == STATUS_BYTES[i]) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PFX_EXT) || (b == PFX_BRK) || (b == PFX_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: first-word-fall-through FIFO of decoded key events.
//   sysclk, reset : clock / async active-high reset (storage is cleared)
//   push, din     : enqueue request and event
//   full          : no free entry
//   pop           : dequeue head (ignored when empty)
//   valid, head   : FIFO non-empty and the entry at the read pointer
//   ovf           : one-cycle pulse when a push is dropped
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     sysclk,
    input  logic     reset,
    input  logic     push,
    input  ps2_evt_t din,
    output logic     full,
    input  logic     pop,
    output logic     valid,
    output ps2_evt_t head,
    output logic     ovf
);
    localparam int AW = $clog2(DEPTH);

    ps2_evt_t        mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;
    logic            do_push, do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign ovf     = push && full && !do_pop;
    assign head    = mem[rptr];

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/scancode_decode.sv
// scancode_decode: folds validated PS/2 Set-2 bytes into single key events.
//   sysclk, reset       : clock / async active-high reset
//   word, done          : parser byte and its one-cycle qualifier
//   evt_ready           : consumer accepts head event
//   evt_valid           : an event is available
//   evt_code/ext/rel/pause : head event fields (code 0x00 for Pause)
//   status              : last keyboard status byte seen
//   seq_err             : sticky, malformed prefix or Pause sequence
//   overflow            : sticky, an event was dropped on a full FIFO
module scancode_decode
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] word,
    input  logic       done,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_rel,
    output logic       evt_pause,
    output logic [7:0] status,
    output logic       seq_err,
    output logic       overflow
);
    dec_state_t state, nxt_state;
    logic [2:0] pidx, nxt_pidx;
    logic       push, set_err, lat_status, idle_path;
    ps2_evt_t   push_evt, head;
    logic       full, ovf;

    always_comb begin
        nxt_state  = state;
        nxt_pidx   = pidx;
        push       = 1'b0;
        push_evt   = '0;
        set_err    = 1'b0;
        lat_status = 1'b0;
        idle_path  = 1'b0;
        if (done) begin
            case (state)
                ST_IDLE: idle_path = 1'b1;
                ST_EXT: begin
                    if (word == PFX_EXT) begin
                        nxt_state = ST_EXT;
                    end else if (word == PFX_BRK) begin
                        nxt_state = ST_EXTBRK;
                    end else if (is_prefix(word) || is_status(word)) begin
                        set_err   = 1'b1;
                        idle_path = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_evt  = '{pause: 1'b0, ext: 1'b1, rel: 1'b0, code: word};
                        nxt_state = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXTBRK: begin
                    if (is_prefix(word) || is_status(word)) begin
                        set_err   = 1'b1;
                        idle_path = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_evt  = '{pause: 1'b0, ext: (state == ST_EXTBRK),
                                      rel: 1'b1, code: word};
                        nxt_state = ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    if (word == PAUSE_TAIL[pidx]) begin
                        if (pidx == 3'(PAUSE_LEN-1)) begin
                            push      = 1'b1;
                            push_evt  = '{pause: 1'b1, ext: 1'b0, rel: 1'b0, code: 8'h00};
                            nxt_state = ST_IDLE;
                            nxt_pidx  = '0;
                        end else begin
                            nxt_pidx = pidx + 1'b1;
                        end
                    end else begin
                        // Mismatch drops the byte outright; it is not re-decoded.
                        set_err   = 1'b1;
                        nxt_state = ST_IDLE;
                        nxt_pidx  = '0;
                    end
                end
                default: nxt_state = ST_IDLE;
            endcase

            // Shared IDLE handling, also used to re-decode a byte that broke a prefix.
            if (idle_path) begin
                nxt_pidx  = '0;
                nxt_state = ST_IDLE;
                if (word == PFX_EXT)        nxt_state = ST_EXT;
                else if (word == PFX_BRK)   nxt_state = ST_BRK;
                else if (word == PFX_PAUSE) nxt_state = ST_PAUSE;
                else if (is_status(word))   lat_status = 1'b1;
                else begin
                    push     = 1'b1;
                    push_evt = '{pause: 1'b0, ext: 1'b0, rel: 1'b0, code: word};
                end
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            pidx     <= '0;
            status   <= '0;
            seq_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= nxt_state;
            pidx  <= nxt_pidx;
            if (lat_status) status <= word;
            if (set_err)    seq_err <= 1'b1;
            if (ovf)        overflow <= 1'b1;
        end
    end

    ps2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .sysclk (sysclk),
        .reset  (reset),
        .push   (push),
        .din    (push_evt),
        .full   (full),
        .pop    (evt_ready),
        .valid  (evt_valid),
        .head   (head),
        .ovf    (ovf)
    );

    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_rel   = head.rel;
    assign evt_pause = head.pause;

endmodule

// File: doc/scancode_decode.md
# scancode_decode

Downstream of the PS/2 frame parser: consumes each validated byte (`word` qualified by the one-cycle `done` pulse) and folds Set-2 scancode sequences into single key events. Prefix state is tracked for extended (E0), break (F0) and the 8-byte Pause (E1…) sequence. Keyboard status bytes are filtered out. Completed events are buffered in a small first-word-fall-through FIFO with a valid/ready handshake toward the keymap/consumer logic.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `sysclk` in 1: system clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high reset.
- `word` in 8: byte from the parser; sampled only when `done`=1.
- `done` in 1: one-cycle strobe marking a new valid byte.
- `evt_ready` in 1: consumer accepts head event when `evt_valid`=1.
- `evt_valid` out 1: FIFO non-empty.
- `evt_code` out 8: head event scancode, or 0x00 for Pause.
- `evt_ext` out 1: head event had E0 prefix.
- `evt_rel` out 1: head event was a release (F0).
- `evt_pause` out 1: head event is Pause.
- `status` out 8: last status byte received.
- `seq_err` out 1: sticky; malformed prefix/Pause sequence seen.
- `overflow` out 1: sticky; event dropped because FIFO full.

## Operation
- Status bytes: 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF. Each is latched into `status` and never enqueued.
- FSM states: IDLE, EXT, BRK, EXTBRK, PAUSE. Transitions occur only on `done`.
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → PAUSE with `pidx`=0.
  - Status byte → latch into `status`, stay IDLE.
  - Any other byte → enqueue {pause 0, ext 0, rel 0, code}, stay IDLE.
- EXT:
  - E0 → stay EXT (repeated prefix is harmless).
  - F0 → EXTBRK.
  - Other non-prefix, non-status byte → enqueue ext=1, go to IDLE.
- BRK: non-prefix, non-status byte → enqueue rel=1, go to IDLE.
- EXTBRK: non-prefix, non-status byte → enqueue ext=1 rel=1, go to IDLE.
- Malformed prefix in EXT/BRK/EXTBRK:
  - Covers any prefix byte other than the EXT cases above, and any status byte.
  - Action: set `seq_err`, then handle the same byte as IDLE would, in the same cycle.
- PAUSE:
  - Expected bytes after E1, in order: 14 77 E1 F0 14 F0 77.
  - Each match increments `pidx`.
  - On the 7th match: enqueue {pause 1, ext 0, rel 0, code 0x00}, go to IDLE.
  - Any mismatch: set `seq_err`, discard the byte, go to IDLE (no reprocessing).
- FIFO: entries are 11 bits {pause, ext, rel, code}.
  - Push = enqueue decision.
  - Pop = `evt_valid && evt_ready`.
  - Push while full with no pop: event dropped, `overflow` set.
  - Push and pop in the same cycle while full: both proceed; count unchanged.
  - Push and pop in the same cycle while empty: not possible, since `evt_valid`=0 when empty.
- Pointers: log2(DEPTH) bits, natural wrap. Count is log2(DEPTH)+1 bits.
- Reset values: FSM=IDLE, `pidx`=0, FIFO empty, `evt_valid`=0, `evt_code`/`evt_ext`/`evt_rel`/`evt_pause` = 0 (storage cleared), `status`=0, `seq_err`=0, `overflow`=0.
- Reset mid-sequence: the partial prefix or Pause progress is lost, and queued events are lost.

## Timing
- `done` high in cycle N → event visible at FIFO head (`evt_valid`=1 if the FIFO was empty) in cycle N+1.
- `status`, `seq_err`, `overflow` update in cycle N+1.
- Head outputs change only on a pop or on a push into an empty FIFO.
- Outputs are stable while `evt_valid`=1 and `evt_ready`=0.
- Throughput: one byte per cycle is accepted. `done` back-to-back in consecutive cycles is legal.
- Asynchronous reset takes effect immediately. Deassertion is assumed synchronous to `sysclk` by the surrounding design.

## Structure
- Package `ps2_pkg` contains:
  - Byte constants: PFX_EXT=E0, PFX_BRK=F0, PFX_PAUSE=E1.
  - The status byte list and a status-byte predicate function.
  - The 7-entry Pause tail constant array.
  - The FSM state enum.
  - The `ps2_evt_t` packed struct {pause, ext, rel, code[7:0]}.
- Sub-module `ps2_evt_fifo`: parameter DEPTH, data type `ps2_evt_t`. Provides push, full, pop, valid, head, and an overflow pulse.
- Decode FSM lives in `scancode_decode`.

## Test plan
- Byte 1C → one event {code 1C, ext 0, rel 0, pause 0}. `evt_valid` rises 1 cycle after `done`.
- Bytes E0 F0 75 → one event {75, ext 1, rel 1}. Bytes F0 1C → {1C, rel 1}.
- Bytes E1 14 77 E1 F0 14 F0 77 → exactly one event {pause 1, code 00}. Bytes E1 14 15 → no event, `seq_err`=1, FSM back in IDLE.
- Bytes F0 E0 74 → `seq_err`=1, event {74, ext 1, rel 0}. Bytes AA, FA → no event, `status`=FA.
- DEPTH=4 with `evt_ready`=0: send 5 make codes 01..05 → FIFO holds 01..04, `overflow`=1. Then `evt_ready`=1 → events 01, 02, 03, 04 are popped on 4 consecutive cycles.
- Assert `reset` between E0 and 75 → all outputs return to 0. Byte 75 afterwards → event {75, ext 0}.
